// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Groups the two buses of the program loader:
//   - byte stream from the host: byte_valid / byte_data in, byte_ready out
//   - instruction-memory write port: mem_we / mem_addr / mem_wdata out
// Modports:
//   master : host / memory side (drives the stream, observes the writes)
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Receives a program image as a byte stream (LEN_HI, LEN_LO, 4*N data bytes,
// checksum), packs the data bytes big-endian into 32-bit words, writes them
// into instruction memory starting at BASE_ADDR and checks the 8-bit
// wrap-around checksum. The CPU core is held in reset until a load finishes
// with a matching checksum.
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous, active-low reset
//   i_start      level; starts a load from IDLE, DONE or ERROR
//   bus          slave side of program_loader_if (byte stream + memory write)
//   o_cpu_reset  active-high reset to the core, low only in DONE
//   o_done       load succeeded
//   o_error      load failed (length too large or checksum mismatch)
// All outputs are registered.
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 256
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    program_loader_if.slave        bus,
    output logic                   o_cpu_reset,
    output logic                   o_done,
    output logic                   o_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t            r_state, w_state_next;
    logic [15:0]       r_len, w_len_next;
    logic [7:0]        r_sum, w_sum_next;
    logic [15:0]       r_word_idx, w_word_idx_next;
    logic [1:0]        r_byte_idx, w_byte_idx_next;
    logic [23:0]       r_word, w_word_next;       // first three bytes of the word in flight
    logic              r_mem_we, w_mem_we_next;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [31:0]       r_mem_wdata, w_mem_wdata_next;
    logic              r_byte_ready, w_byte_ready_next;
    logic              r_cpu_reset, w_cpu_reset_next;
    logic              r_done, w_done_next;
    logic              r_error, w_error_next;

    logic              w_xfer;
    logic [15:0]       w_len_rx;
    logic [15:0]       w_word_idx_inc;
    logic [ADDR_W-1:0] w_addr;

    assign w_xfer         = bus.byte_valid && r_byte_ready;
    assign w_len_rx       = {r_len[15:8], bus.byte_data};
    assign w_word_idx_inc = r_word_idx + 16'd1;
    // Address wraps naturally at ADDR_W bits.
    assign w_addr         = ADDR_W'(BASE_ADDR) + ADDR_W'(r_word_idx);

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_len_next       = r_len;
        w_sum_next       = r_sum;
        w_word_idx_next  = r_word_idx;
        w_byte_idx_next  = r_byte_idx;
        w_word_next      = r_word;
        w_mem_we_next    = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    w_state_next    = ST_LEN_HI;
                    w_sum_next      = 8'd0;
                    w_word_idx_next = 16'd0;
                    w_byte_idx_next = 2'd0;
                end
            end
            ST_LEN_HI: begin
                if (w_xfer) begin
                    w_len_next   = {bus.byte_data, r_len[7:0]};
                    w_sum_next   = r_sum + bus.byte_data;
                    w_state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    w_len_next = w_len_rx;
                    w_sum_next = r_sum + bus.byte_data;
                    if ({1'b0, w_len_rx} > 17'(MAX_WORDS)) begin
                        w_state_next = ST_ERROR;
                    end else if (w_len_rx == 16'd0) begin
                        w_state_next = ST_CSUM;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    w_sum_next  = r_sum + bus.byte_data;
                    w_word_next = {r_word[15:0], bus.byte_data};
                    if (r_byte_idx == 2'd3) begin
                        // Word complete: write it on this same edge.
                        w_mem_we_next    = 1'b1;
                        w_mem_addr_next  = w_addr;
                        w_mem_wdata_next = {r_word, bus.byte_data};
                        w_word_idx_next  = w_word_idx_inc;
                        w_byte_idx_next  = 2'd0;
                        if (w_word_idx_inc == r_len) begin
                            w_state_next = ST_CSUM;
                        end
                    end else begin
                        w_byte_idx_next = r_byte_idx + 2'd1;
                    end
                end
            end
            ST_CSUM: begin
                if (w_xfer) begin
                    w_state_next = (bus.byte_data == r_sum) ? ST_DONE : ST_ERROR;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Status outputs are a function of the state being entered, so they
        // change on the same edge as the state does.
        w_byte_ready_next = (w_state_next == ST_LEN_HI) || (w_state_next == ST_LEN_LO) ||
                            (w_state_next == ST_DATA)   || (w_state_next == ST_CSUM);
        w_done_next       = (w_state_next == ST_DONE);
        w_error_next      = (w_state_next == ST_ERROR);
        w_cpu_reset_next  = (w_state_next != ST_DONE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_len        <= 16'd0;
            r_sum        <= 8'd0;
            r_word_idx   <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_word       <= 24'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= ADDR_W'(BASE_ADDR);
            r_mem_wdata  <= 32'd0;
            r_byte_ready <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_len        <= w_len_next;
            r_sum        <= w_sum_next;
            r_word_idx   <= w_word_idx_next;
            r_byte_idx   <= w_byte_idx_next;
            r_word       <= w_word_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_byte_ready <= w_byte_ready_next;
            r_cpu_reset  <= w_cpu_reset_next;
            r_done       <= w_done_next;
            r_error      <= w_error_next;
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_done         = r_done;
    assign o_error        = r_error;

endmodule
